// File: rtl/instr_sequencer_if.sv
// Bus bundle between the host/processor side and the instruction sequencer.
// master: host and processor side (drives program, start, proc_result).
// slave:  the sequencer itself.
interface instr_sequencer_if #(
   parameter int AW = 4
);
   logic          prog_we;
   logic [AW-1:0] prog_addr;
   logic [19:0]   prog_data;
   logic [AW:0]   prog_len;
   logic          start;
   logic [19:0]   instruction;
   logic          op;
   logic [7:0]    proc_result;
   logic          res_valid;
   logic [7:0]    res_data;
   logic [AW-1:0] res_addr;
   logic          busy;
   logic          done;

   modport master (
      output prog_we, prog_addr, prog_data, prog_len, start, proc_result,
      input  instruction, op, res_valid, res_data, res_addr, busy, done
   );

   modport slave (
      input  prog_we, prog_addr, prog_data, prog_len, start, proc_result,
      output instruction, op, res_valid, res_data, res_addr, busy, done
   );
endinterface

// File: rtl/instr_sequencer.sv
// Program-side driver for the 8-bit accumulator processor.
// Holds a small instruction store, issues each word with a one-cycle op
// strobe, waits a fixed number of cycles and captures the processor result
// tagged with the address of the instruction that produced it.
module instr_sequencer #(
   parameter int         DEPTH       = 16,
   parameter int         AW          = 4,
   parameter int         WAIT_CYCLES = 3,
   parameter logic [3:0] HALT_OP     = 4'hF
) (
   input logic               clk,
   input logic               reset,
   instr_sequencer_if.slave  bus
);

   localparam int            CW      = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
   localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);
   localparam logic [CW-1:0] WAIT_L  = CW'(WAIT_CYCLES);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t        state;
   logic [19:0]   mem [DEPTH];
   logic [AW-1:0] pc;
   logic [AW:0]   len;
   logic [CW-1:0] cnt;

   logic [19:0]   cur_word;
   logic          cur_halt;
   logic          last_instr;
   logic [AW:0]   start_len;

   logic [19:0]   instruction_q;
   logic          op_q;
   logic          res_valid_q;
   logic [7:0]    res_data_q;
   logic [AW-1:0] res_addr_q;
   logic          busy_q;
   logic          done_q;

   assign bus.instruction = instruction_q;
   assign bus.op          = op_q;
   assign bus.res_valid   = res_valid_q;
   assign bus.res_data    = res_data_q;
   assign bus.res_addr    = res_addr_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;

   // Decode the word at pc, the end-of-program test and the saturated length.
   always_comb begin
      cur_word   = mem[pc];
      cur_halt   = (cur_word[19:16] == HALT_OP);
      last_instr = ({1'b0, pc} == (len - (AW + 1)'(1)));
      start_len  = (bus.prog_len > DEPTH_L) ? DEPTH_L : bus.prog_len;
   end

   // Instruction store: no reset so the program survives a reset; writable only while idle.
   always_ff @(posedge clk) begin
      if (bus.prog_we && (state == S_IDLE)) begin
         mem[bus.prog_addr] <= bus.prog_data;
      end
   end

   // Sequencer FSM with registered strobes and result capture.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= S_IDLE;
         pc            <= '0;
         len           <= '0;
         cnt           <= '0;
         instruction_q <= '0;
         op_q          <= 1'b0;
         res_valid_q   <= 1'b0;
         res_data_q    <= '0;
         res_addr_q    <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         op_q        <= 1'b0;
         res_valid_q <= 1'b0;
         done_q      <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  len    <= start_len;
                  pc     <= '0;
                  busy_q <= 1'b1;
                  state  <= (bus.prog_len == '0) ? S_DONE : S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (cur_halt) begin
                  state <= S_DONE;
               end else begin
                  instruction_q <= cur_word;
                  op_q          <= 1'b1;
                  cnt           <= WAIT_L;
                  state         <= S_WAIT;
               end
            end
            S_WAIT: begin
               cnt <= cnt - CNT_ONE;
               if (cnt == CNT_ONE) begin
                  state <= S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               res_data_q  <= bus.proc_result;
               res_addr_q  <= pc;
               res_valid_q <= 1'b1;
               if (last_instr) begin
                  state <= S_DONE;
               end else begin
                  pc    <= pc + AW'(1);
                  state <= S_ISSUE;
               end
            end
            S_DONE: begin
               done_q <= 1'b1;
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed vector table, hand-written
// corner sequences and randomized programs against a latency/result model.
module tb_instr_sequencer;

   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int W     = 3;

   typedef struct {
      int          cyc;
      logic [19:0] ins;
   } op_ev_t;

   typedef struct {
      int         cyc;
      int         addr;
      logic [7:0] data;
   } res_ev_t;

   typedef struct {
      logic [19:0] w0;
      logic [19:0] w1;
      logic [19:0] w2;
      logic [19:0] w3;
      int          len;
      int          e_ops;
      int          e_res;
      int          e_done;
      logic [7:0]  e_first;
   } vec_t;

   logic clk;
   logic rst_n;

   instr_sequencer_if #(.AW(AW)) bus ();

   instr_sequencer #(
      .DEPTH      (DEPTH),
      .AW         (AW),
      .WAIT_CYCLES(W),
      .HALT_OP    (4'hF)
   ) dut (
      .clk  (clk),
      .reset(rst_n),
      .bus  (bus)
   );

   int pass_cnt;
   int total_cnt;

   logic [19:0] shadow [DEPTH];
   op_ev_t      exp_op[$];
   res_ev_t     exp_res[$];
   int          exp_done;
   op_ev_t      act_op[$];
   res_ev_t     act_res[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [7:0] alu(input logic [19:0] w);
      logic [7:0] a;
      logic [7:0] b;
      a = w[7:0];
      b = w[15:8];
      case (w[19:16])
         4'h0:    return a + b;
         4'h1:    return a - b;
         4'h2:    return a & b;
         4'h3:    return a | b;
         4'h4:    return a ^ b;
         default: return b;
      endcase
   endfunction

   // Processor stand-in: result appears exactly W cycles after the op strobe.
   logic [7:0] proc_q;
   logic [7:0] pend;
   logic       armed;
   int         cd;
   assign bus.proc_result = proc_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         proc_q <= 8'h00;
         pend   <= 8'h00;
         armed  <= 1'b0;
         cd     <= 0;
      end else begin
         if (armed) begin
            if (cd == 0) begin
               proc_q <= pend;
               armed  <= 1'b0;
            end else begin
               cd <= cd - 1;
            end
         end
         if (bus.op) begin
            pend  <= alu(bus.instruction);
            cd    <= W - 2;
            armed <= 1'b1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total_cnt++;
      if (act === req) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Expected behaviour from the program rules: each issued word costs W+2
   // cycles, a halt word costs one extra cycle, done follows one cycle later.
   task automatic model(input int len);
      int n_lim;
      int n;
      int halted;
      exp_op.delete();
      exp_res.delete();
      n_lim  = (len > DEPTH) ? DEPTH : len;
      n      = 0;
      halted = 0;
      for (int i = 0; i < n_lim; i++) begin
         if (shadow[i][19:16] == 4'hF) begin
            halted = 1;
            break;
         end
         exp_op.push_back('{1 + i * (W + 2), shadow[i]});
         exp_res.push_back('{(i + 1) * (W + 2), i, alu(shadow[i])});
         n++;
      end
      exp_done = n * (W + 2) + 1 + halted;
   endtask

   task automatic write_mem(input int addr, input logic [19:0] data);
      bus.prog_we   = 1'b1;
      bus.prog_addr = 4'(addr);
      bus.prog_data = data;
      shadow[addr]  = data;
      @(posedge clk);
      @(negedge clk);
      bus.prog_we = 1'b0;
   endtask

   task automatic load4(input logic [19:0] a, input logic [19:0] b,
                        input logic [19:0] c, input logic [19:0] d);
      write_mem(0, a);
      write_mem(1, b);
      write_mem(2, c);
      write_mem(3, d);
   endtask

   // Starts a program (called at a negedge), watches it to the done pulse and
   // compares every observed event against the model.
   task automatic run_prog(input int len, input string tag, input int inject_c,
                           input bit wr_start, input logic [19:0] wr_word,
                           output int n_ops, output int n_res, output int done_c,
                           output logic [7:0] first_data);
      int busy_bad;
      int overlap;
      int halt_issue;
      act_op.delete();
      act_res.delete();
      busy_bad   = 0;
      overlap    = 0;
      halt_issue = 0;
      done_c     = -1;
      bus.prog_len = 5'(len);
      bus.start    = 1'b1;
      if (wr_start) begin
         bus.prog_we   = 1'b1;
         bus.prog_addr = 4'd0;
         bus.prog_data = wr_word;
         shadow[0]     = wr_word;
      end
      model(len);
      @(posedge clk);
      @(negedge clk);
      bus.start   = 1'b0;
      bus.prog_we = 1'b0;
      chk({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
      for (int c = 1; c <= 300; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.op) begin
            act_op.push_back('{c, bus.instruction});
            if (bus.instruction[19:16] == 4'hF) halt_issue++;
         end
         if (bus.res_valid) act_res.push_back('{c, 32'(bus.res_addr), bus.res_data});
         if (bus.res_valid && bus.done) overlap++;
         if (bus.done) begin
            done_c = c;
            chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
            break;
         end
         if (!bus.busy) busy_bad++;
         if (c == inject_c) begin
            bus.start     = 1'b1;
            bus.prog_we   = 1'b1;
            bus.prog_addr = 4'd1;
            bus.prog_data = 20'hABCDE;
         end else if (c == inject_c + 1) begin
            bus.start   = 1'b0;
            bus.prog_we = 1'b0;
         end
      end
      bus.start   = 1'b0;
      bus.prog_we = 1'b0;
      @(negedge clk);
      chk({tag, "_done_width"}, 32'(bus.done), 32'd0);
      chk({tag, "_done_cycle"}, 32'(done_c), 32'(exp_done));
      chk({tag, "_n_ops"}, 32'(act_op.size()), 32'(exp_op.size()));
      chk({tag, "_n_res"}, 32'(act_res.size()), 32'(exp_res.size()));
      for (int i = 0; i < act_op.size() && i < exp_op.size(); i++) begin
         chk($sformatf("%s_op%0d_cyc", tag, i), 32'(act_op[i].cyc), 32'(exp_op[i].cyc));
         chk($sformatf("%s_op%0d_ins", tag, i), 32'(act_op[i].ins), 32'(exp_op[i].ins));
      end
      for (int i = 0; i < act_res.size() && i < exp_res.size(); i++) begin
         chk($sformatf("%s_res%0d_cyc", tag, i), 32'(act_res[i].cyc), 32'(exp_res[i].cyc));
         chk($sformatf("%s_res%0d_addr", tag, i), 32'(act_res[i].addr), 32'(exp_res[i].addr));
         chk($sformatf("%s_res%0d_data", tag, i), 32'(act_res[i].data), 32'(exp_res[i].data));
      end
      chk({tag, "_busy_gap"}, 32'(busy_bad), 32'd0);
      chk({tag, "_valid_done_overlap"}, 32'(overlap), 32'd0);
      chk({tag, "_halt_issued"}, 32'(halt_issue), 32'd0);
      n_ops      = act_op.size();
      n_res      = act_res.size();
      first_data = (act_res.size() > 0) ? act_res[0].data : 8'h00;
   endtask

   vec_t        vt [7];
   int          n_ops;
   int          n_res;
   int          done_c;
   logic [7:0]  first_data;
   int          done_seen;

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;

      vt[0] = '{20'h00503, 20'h01020, 20'h20F3C, 20'h00000, 3, 3, 3, 16, 8'h08};
      vt[1] = '{20'h00503, 20'hF0000, 20'h01111, 20'h02222, 4, 1, 1, 7, 8'h08};
      vt[2] = '{20'h00503, 20'h00000, 20'h00000, 20'h00000, 0, 0, 0, 1, 8'h00};
      vt[3] = '{20'hF1234, 20'h00503, 20'h00000, 20'h00000, 2, 0, 0, 2, 8'h00};
      vt[4] = '{20'h00503, 20'h00000, 20'h00000, 20'h00000, 1, 1, 1, 6, 8'h08};
      vt[5] = '{20'h1030A, 20'h00000, 20'h00000, 20'h00000, 1, 1, 1, 6, 8'h07};
      vt[6] = '{20'h4FF0F, 20'h3F00F, 20'h2AA55, 20'h10100, 4, 4, 4, 21, 8'hF0};

      rst_n         = 1'b0;
      bus.prog_we   = 1'b0;
      bus.prog_addr = '0;
      bus.prog_data = '0;
      bus.prog_len  = '0;
      bus.start     = 1'b0;
      for (int i = 0; i < DEPTH; i++) shadow[i] = 20'h0;

      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_op", 32'(bus.op), 32'd0);
      chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_instruction", 32'(bus.instruction), 32'd0);
      chk("rst_res_data", 32'(bus.res_data), 32'd0);
      chk("rst_res_addr", 32'(bus.res_addr), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed vector table.
      for (int v = 0; v < 7; v++) begin
         load4(vt[v].w0, vt[v].w1, vt[v].w2, vt[v].w3);
         for (int i = 4; i < DEPTH; i++) write_mem(i, 20'h00000);
         run_prog(vt[v].len, $sformatf("vec%0d", v), -10, 1'b0, 20'h0,
                  n_ops, n_res, done_c, first_data);
         chk($sformatf("vec%0d_tab_ops", v), 32'(n_ops), 32'(vt[v].e_ops));
         chk($sformatf("vec%0d_tab_res", v), 32'(n_res), 32'(vt[v].e_res));
         chk($sformatf("vec%0d_tab_done", v), 32'(done_c), 32'(vt[v].e_done));
         chk($sformatf("vec%0d_tab_first", v), 32'(first_data), 32'(vt[v].e_first));
      end

      // start and prog_we during WAIT are both ignored; rerun proves mem[1] intact.
      load4(vt[0].w0, vt[0].w1, vt[0].w2, vt[0].w3);
      run_prog(3, "wait_inject", 2, 1'b0, 20'h0, n_ops, n_res, done_c, first_data);
      run_prog(3, "after_inject", -10, 1'b0, 20'h0, n_ops, n_res, done_c, first_data);

      // Write and start in the same idle cycle: the new word is the one issued.
      run_prog(3, "start_write", -10, 1'b1, 20'h02022, n_ops, n_res, done_c, first_data);
      chk("start_write_first", 32'(first_data), 32'h42);

      // Reset during WAIT of instruction 1, then rerun the preserved program.
      bus.prog_len = 5'd3;
      bus.start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         @(posedge clk);
         @(negedge clk);
      end
      chk("midrst_busy_before", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_op", 32'(bus.op), 32'd0);
      chk("midrst_res_valid", 32'(bus.res_valid), 32'd0);
      chk("midrst_instruction", 32'(bus.instruction), 32'd0);
      chk("midrst_res_data", 32'(bus.res_data), 32'd0);
      done_seen = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (bus.done) done_seen++;
      end
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (bus.done) done_seen++;
      end
      chk("midrst_no_done", 32'(done_seen), 32'd0);
      run_prog(3, "after_reset", -10, 1'b0, 20'h0, n_ops, n_res, done_c, first_data);

      // Full store, oversize length: runs exactly DEPTH instructions.
      for (int i = 0; i < DEPTH; i++) write_mem(i, {4'($urandom_range(0, 4)), 16'($urandom)});
      run_prog(31, "saturate", -10, 1'b0, 20'h0, n_ops, n_res, done_c, first_data);
      chk("saturate_ops", 32'(n_ops), 32'(DEPTH));

      // Randomized programs, including occasional halt words and oversize lengths.
      for (int r = 0; r < 10; r++) begin
         for (int i = 0; i < DEPTH; i++) begin
            logic [3:0] opc;
            opc = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 4));
            write_mem(i, {opc, 16'($urandom)});
         end
         run_prog($urandom_range(0, 20), $sformatf("rand%0d", r), -10, 1'b0, 20'h0,
                  n_ops, n_res, done_c, first_data);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
